// File: rtl/nios_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage NIOS II subset core: forwarding, load-use stall,
// branch flush and halt sequencing. Define NIOS_HAZARD_PERF_EN to add stall/flush cycle counters.
module nios_hazard_ctrl #(
    parameter int              PC_W         = 6,
    parameter int              FLUSH_CYCLES = 2,
    parameter logic [PC_W-1:0] HALT_PC      = 6'h0E
) (
    input  logic            clk_18,
    input  logic            rst_18,
    input  logic            valid_D_18,
    input  logic [4:0]      rs_D_18,
    input  logic [4:0]      rt_D_18,
    input  logic            uses_rt_D_18,
    input  logic [4:0]      rd_E_18,
    input  logic            reg_rw_E_18,
    input  logic            is_load_E_18,
    input  logic [4:0]      rd_M_18,
    input  logic            reg_rw_M_18,
    input  logic [4:0]      rd_WB_18,
    input  logic            reg_rw_WB_18,
    input  logic            branch_taken_E_18,
    input  logic [PC_W-1:0] branch_tgt_E_18,
    input  logic [PC_W-1:0] pc_F_18,
    output logic            stall_F_18,
    output logic            stall_D_18,
    output logic            bubble_E_18,
    output logic            flush_D_18,
    output logic            pc_load_18,
    output logic [PC_W-1:0] pc_tgt_18,
    output logic [1:0]      fwd_a_sel_18,
    output logic [1:0]      fwd_b_sel_18,
    output logic            halted_18
`ifdef NIOS_HAZARD_PERF_EN
    ,
    output logic [15:0]     stall_cnt_18,
    output logic [15:0]     flush_cnt_18
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        LSTALL = 2'b01,
        FLUSH  = 2'b10,
        HALT   = 2'b11
    } state_t;

    localparam int CNT_W = 3;

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic              load_use_s;
    logic              fwd_en_s;
    logic              stall_f_s, stall_d_s, bubble_e_s, flush_d_s, pc_load_s, halted_s;
    logic [PC_W-1:0]   pc_tgt_s;
    logic [1:0]        fwd_a_s, fwd_b_s;

    // Loads are never forwarded from E: their data only exists from M onward.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] rd_e, input logic rw_e, input logic ld_e,
        input logic [4:0] rd_m, input logic rw_m,
        input logic [4:0] rd_wb, input logic rw_wb
    );
        logic [1:0] sel;
        if (rw_e && !ld_e && (rd_e != 5'd0) && (rd_e == src)) begin
            sel = 2'b01;
        end else if (rw_m && (rd_m != 5'd0) && (rd_m == src)) begin
            sel = 2'b10;
        end else if (rw_wb && (rd_wb != 5'd0) && (rd_wb == src)) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign load_use_s = valid_D_18 && is_load_E_18 && reg_rw_E_18 && (rd_E_18 != 5'd0) &&
                        ((rd_E_18 == rs_D_18) || (uses_rt_D_18 && (rd_E_18 == rt_D_18)));

    // Next-state and raw control outputs from the current state.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        fwd_en_s    = 1'b0;
        stall_f_s   = 1'b0;
        stall_d_s   = 1'b0;
        bubble_e_s  = 1'b0;
        flush_d_s   = 1'b0;
        pc_load_s   = 1'b0;
        pc_tgt_s    = {PC_W{1'b0}};
        halted_s    = 1'b0;
        case (state_r)
            RUN: begin
                fwd_en_s = 1'b1;
                if (branch_taken_E_18) begin
                    pc_load_s = 1'b1;
                    pc_tgt_s  = branch_tgt_E_18;
                    flush_d_s = 1'b1;
                    if (FLUSH_CYCLES == 1) begin
                        state_nxt_s = RUN;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s = FLUSH;
                        cnt_nxt_s   = CNT_W'(FLUSH_CYCLES - 1);
                    end
                end else if (load_use_s) begin
                    stall_f_s   = 1'b1;
                    stall_d_s   = 1'b1;
                    bubble_e_s  = 1'b1;
                    state_nxt_s = LSTALL;
                end else if (pc_F_18 == HALT_PC) begin
                    state_nxt_s = HALT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            LSTALL: begin
                fwd_en_s    = 1'b1;
                state_nxt_s = RUN;
            end
            FLUSH: begin
                flush_d_s = 1'b1;
                if (cnt_r <= CNT_W'(1)) begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            HALT: begin
                stall_f_s = 1'b1;
                halted_s  = 1'b1;
            end
            default: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Forward selects, qualified by state and a live decode instruction.
    always_comb begin
        fwd_a_s = 2'b00;
        fwd_b_s = 2'b00;
        if (fwd_en_s && valid_D_18) begin
            fwd_a_s = fwd_sel(rs_D_18, rd_E_18, reg_rw_E_18, is_load_E_18,
                              rd_M_18, reg_rw_M_18, rd_WB_18, reg_rw_WB_18);
            if (uses_rt_D_18) begin
                fwd_b_s = fwd_sel(rt_D_18, rd_E_18, reg_rw_E_18, is_load_E_18,
                                  rd_M_18, reg_rw_M_18, rd_WB_18, reg_rw_WB_18);
            end else begin
                fwd_b_s = 2'b00;
            end
        end else begin
            fwd_a_s = 2'b00;
            fwd_b_s = 2'b00;
        end
    end

    // Outputs are forced quiet while reset is held.
    always_comb begin
        stall_F_18   = 1'b0;
        stall_D_18   = 1'b0;
        bubble_E_18  = 1'b0;
        flush_D_18   = 1'b0;
        pc_load_18   = 1'b0;
        pc_tgt_18    = {PC_W{1'b0}};
        fwd_a_sel_18 = 2'b00;
        fwd_b_sel_18 = 2'b00;
        halted_18    = 1'b0;
        if (!rst_18) begin
            stall_F_18   = stall_f_s;
            stall_D_18   = stall_d_s;
            bubble_E_18  = bubble_e_s;
            flush_D_18   = flush_d_s;
            pc_load_18   = pc_load_s;
            pc_tgt_18    = pc_tgt_s;
            fwd_a_sel_18 = fwd_a_s;
            fwd_b_sel_18 = fwd_b_s;
            halted_18    = halted_s;
        end else begin
            halted_18    = 1'b0;
        end
    end

    // State and flush counter registers.
    always_ff @(posedge clk_18) begin
        if (rst_18) begin
            state_r <= RUN;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

`ifdef NIOS_HAZARD_PERF_EN
    logic [15:0] stall_cnt_r, flush_cnt_r;

    // Saturating stall / flush cycle counters.
    always_ff @(posedge clk_18) begin
        if (rst_18) begin
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            if (stall_D_18 && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
            if (flush_D_18 && (flush_cnt_r != 16'hFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 16'd1;
            end
        end
    end

    assign stall_cnt_18 = stall_cnt_r;
    assign flush_cnt_18 = flush_cnt_r;
`endif

endmodule

// File: tb/tb_nios_hazard_ctrl.sv
// Self-checking bench for nios_hazard_ctrl: vector table, hand sequences, and random
// stimulus against a cycle-level reference model.
module tb_nios_hazard_ctrl;

    localparam int          PC_W    = 6;
    localparam int          FLUSH_N = 2;
    localparam logic [5:0]  HALT_PC = 6'h0E;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid, uses_rt, rw_e, ld_e, rw_m, rw_wb, br;
    logic [4:0] rs, rt, rd_e, rd_m, rd_wb;
    logic [5:0] tgt, pc;
    logic       stall_f, stall_d, bubble_e, flush_d, pc_load, halted;
    logic [5:0] pc_tgt;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] outs_s;
`ifdef NIOS_HAZARD_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nios_hazard_ctrl #(.PC_W(PC_W), .FLUSH_CYCLES(FLUSH_N), .HALT_PC(HALT_PC)) dut (
        .clk_18(clk), .rst_18(rst), .valid_D_18(valid), .rs_D_18(rs), .rt_D_18(rt),
        .uses_rt_D_18(uses_rt), .rd_E_18(rd_e), .reg_rw_E_18(rw_e), .is_load_E_18(ld_e),
        .rd_M_18(rd_m), .reg_rw_M_18(rw_m), .rd_WB_18(rd_wb), .reg_rw_WB_18(rw_wb),
        .branch_taken_E_18(br), .branch_tgt_E_18(tgt), .pc_F_18(pc),
        .stall_F_18(stall_f), .stall_D_18(stall_d), .bubble_E_18(bubble_e),
        .flush_D_18(flush_d), .pc_load_18(pc_load), .pc_tgt_18(pc_tgt),
        .fwd_a_sel_18(fwd_a), .fwd_b_sel_18(fwd_b), .halted_18(halted)
`ifdef NIOS_HAZARD_PERF_EN
        , .stall_cnt_18(stall_cnt), .flush_cnt_18(flush_cnt)
`endif
    );

    assign outs_s = {stall_f, stall_d, bubble_e, flush_d, pc_load, pc_tgt, fwd_a, fwd_b, halted};

    typedef struct {
        string       name;
        logic        valid, uses_rt, rw_e, ld_e, rw_m, rw_wb, br;
        logic [4:0]  rs, rt, rd_e, rd_m, rd_wb;
        logic [5:0]  tgt, pc;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] exp_o(logic sf, logic sd, logic be, logic fl, logic pl,
                                          logic [5:0] t, logic [1:0] fa, logic [1:0] fb, logic h);
        return {sf, sd, be, fl, pl, t, fa, fb, h};
    endfunction

    function automatic vec_t idle_vec();
        vec_t v;
        v.name = "idle"; v.valid = 1'b0; v.uses_rt = 1'b0; v.rw_e = 1'b0; v.ld_e = 1'b0;
        v.rw_m = 1'b0; v.rw_wb = 1'b0; v.br = 1'b0; v.rs = 5'd0; v.rt = 5'd0;
        v.rd_e = 5'd0; v.rd_m = 5'd0; v.rd_wb = 5'd0; v.tgt = 6'd0; v.pc = 6'd1;
        v.exp = 16'd0;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        valid = v.valid; uses_rt = v.uses_rt; rw_e = v.rw_e; ld_e = v.ld_e; rw_m = v.rw_m;
        rw_wb = v.rw_wb; br = v.br; rs = v.rs; rt = v.rt; rd_e = v.rd_e; rd_m = v.rd_m;
        rd_wb = v.rd_wb; tgt = v.tgt; pc = v.pc;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input string name, input logic [15:0] exp);
        @(negedge clk);
        check(name, outs_s, exp);
        @(posedge clk); #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        apply(idle_vec());
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Reference model: what the controller is still owed from earlier cycles.
    bit m_halted, m_after_stall;
    int m_flush_left;

    function automatic logic [1:0] model_src(logic [4:0] src);
        logic [4:0] rds[3];
        logic       wr[3];
        rds[0] = rd_e;  wr[0] = rw_e && !ld_e;
        rds[1] = rd_m;  wr[1] = rw_m;
        rds[2] = rd_wb; wr[2] = rw_wb;
        for (int i = 0; i < 3; i++) begin
            if (wr[i] && rds[i] != 5'd0 && rds[i] == src) return 2'(i + 1);
        end
        return 2'd0;
    endfunction

    task automatic model_cycle(output logic [15:0] exp);
        logic sf, sd, be, fl, pl, h;
        logic [5:0] t;
        logic [1:0] fa, fb;
        logic lu;
        sf = 0; sd = 0; be = 0; fl = 0; pl = 0; h = 0; t = 6'd0; fa = 2'd0; fb = 2'd0;
        lu = valid && ld_e && rw_e && rd_e != 5'd0 && (rd_e == rs || (uses_rt && rd_e == rt));
        if (rst) begin
            m_halted = 0; m_after_stall = 0; m_flush_left = 0;
        end else if (m_halted) begin
            sf = 1; h = 1;
        end else if (m_flush_left > 0) begin
            fl = 1;
            m_flush_left--;
        end else begin
            if (valid) begin
                fa = model_src(rs);
                fb = uses_rt ? model_src(rt) : 2'd0;
            end
            if (m_after_stall) begin
                m_after_stall = 0;
            end else if (br) begin
                pl = 1; t = tgt; fl = 1;
                m_flush_left = FLUSH_N - 1;
            end else if (lu) begin
                sf = 1; sd = 1; be = 1;
                m_after_stall = 1;
            end else if (pc == HALT_PC) begin
                m_halted = 1;
            end
        end
        exp = exp_o(sf, sd, be, fl, pl, t, fa, fb, h);
    endtask

    initial begin
        vec_t v;
        logic [15:0] e;
        rst = 1'b1;
        apply(idle_vec());
        br = 1'b1; tgt = 6'h2A;
        @(posedge clk); #1;
        step("reset_quiet", 16'd0);
        rst = 1'b0;

        // Single-cycle vectors, each from a fresh RUN state.
        v = idle_vec(); v.name = "fwd_m_wb"; v.valid = 1; v.rs = 5'd2; v.rt = 5'd3; v.uses_rt = 1;
        v.rd_m = 5'd2; v.rw_m = 1; v.rd_wb = 5'd3; v.rw_wb = 1; v.rd_e = 5'd7; v.rw_e = 1;
        v.exp = exp_o(0, 0, 0, 0, 0, 6'd0, 2'b10, 2'b11, 0); vecs.push_back(v);
        v = idle_vec(); v.name = "fwd_e_prio"; v.valid = 1; v.rs = 5'd5; v.rt = 5'd6; v.uses_rt = 1;
        v.rd_e = 5'd5; v.rw_e = 1; v.rd_m = 5'd5; v.rw_m = 1;
        v.exp = exp_o(0, 0, 0, 0, 0, 6'd0, 2'b01, 2'b00, 0); vecs.push_back(v);
        v = idle_vec(); v.name = "load_use_m"; v.valid = 1; v.rs = 5'd5;
        v.rd_e = 5'd5; v.rw_e = 1; v.ld_e = 1; v.rd_m = 5'd5; v.rw_m = 1;
        v.exp = exp_o(1, 1, 1, 0, 0, 6'd0, 2'b10, 2'b00, 0); vecs.push_back(v);
        v = idle_vec(); v.name = "r0_ignored"; v.valid = 1; v.uses_rt = 1;
        v.rw_e = 1; v.ld_e = 1; v.rw_m = 1; v.rw_wb = 1;
        v.exp = 16'd0; vecs.push_back(v);
        v = idle_vec(); v.name = "no_rt"; v.valid = 1; v.rs = 5'd1; v.rt = 5'd4;
        v.rd_e = 5'd4; v.rw_e = 1; v.ld_e = 1; v.rd_m = 5'd4; v.rw_m = 1;
        v.exp = 16'd0; vecs.push_back(v);
        v = idle_vec(); v.name = "invalid_d"; v.rs = 5'd4; v.rd_e = 5'd4; v.rw_e = 1; v.ld_e = 1;
        v.rd_m = 5'd4; v.rw_m = 1;
        v.exp = 16'd0; vecs.push_back(v);
        v = idle_vec(); v.name = "branch_over_lu"; v.valid = 1; v.rs = 5'd4; v.rd_e = 5'd4;
        v.rw_e = 1; v.ld_e = 1; v.br = 1; v.tgt = 6'h05;
        v.exp = exp_o(0, 0, 0, 1, 1, 6'h05, 2'b00, 2'b00, 0); vecs.push_back(v);
        v = idle_vec(); v.name = "e_nowrite_wb"; v.valid = 1; v.rs = 5'd3; v.rd_e = 5'd3;
        v.rd_wb = 5'd3; v.rw_wb = 1;
        v.exp = exp_o(0, 0, 0, 0, 0, 6'd0, 2'b11, 2'b00, 0); vecs.push_back(v);
        v = idle_vec(); v.name = "halt_pc_cycle"; v.pc = HALT_PC;
        v.exp = 16'd0; vecs.push_back(v);
        v = idle_vec(); v.name = "plain"; v.valid = 1; v.rs = 5'd9; v.rt = 5'd10; v.uses_rt = 1;
        v.exp = 16'd0; vecs.push_back(v);

        foreach (vecs[i]) begin
            reset_pulse();
            apply(vecs[i]);
            step(vecs[i].name, vecs[i].exp);
        end

        // Load-use: stall, LSTALL forwarding from M, then back in RUN.
        reset_pulse();
        v = idle_vec(); v.valid = 1; v.rs = 5'd4; v.rd_e = 5'd4; v.rw_e = 1; v.ld_e = 1; apply(v);
        step("lu_c0", exp_o(1, 1, 1, 0, 0, 6'd0, 2'b00, 2'b00, 0));
        v = idle_vec(); v.valid = 1; v.rs = 5'd4; v.rd_m = 5'd4; v.rw_m = 1; v.br = 1; apply(v);
        step("lu_c1", exp_o(0, 0, 0, 0, 0, 6'd0, 2'b10, 2'b00, 0));
        v = idle_vec(); v.valid = 1; v.rs = 5'd6; v.rd_e = 5'd6; v.rw_e = 1; v.ld_e = 1; apply(v);
        step("lu_c2_run", exp_o(1, 1, 1, 0, 0, 6'd0, 2'b00, 2'b00, 0));

        // Taken branch: two flush cycles, branch in FLUSH ignored, then RUN.
        reset_pulse();
        v = idle_vec(); v.valid = 1; v.rs = 5'd4; v.rd_e = 5'd4; v.rw_e = 1; v.ld_e = 1;
        v.br = 1; v.tgt = 6'h05; apply(v);
        step("br_c0", exp_o(0, 0, 0, 1, 1, 6'h05, 2'b00, 2'b00, 0));
        v.tgt = 6'h09; apply(v);
        step("br_c1", exp_o(0, 0, 0, 1, 0, 6'd0, 2'b00, 2'b00, 0));
        apply(idle_vec());
        step("br_c2", 16'd0);

        // Halt and recovery by reset.
        reset_pulse();
        v = idle_vec(); v.pc = HALT_PC; apply(v);
        step("halt_entry", 16'd0);
        v = idle_vec(); v.valid = 1; v.rs = 5'd4; v.rd_e = 5'd4; v.rw_e = 1; v.ld_e = 1;
        v.br = 1; v.tgt = 6'h11; apply(v);
        for (int i = 0; i < 20; i++) step("halt_hold", exp_o(1, 0, 0, 0, 0, 6'd0, 2'b00, 2'b00, 1));
        rst = 1'b1;
        step("halt_rst", 16'd0);
        rst = 1'b0;
        v.br = 0; apply(v);
        step("halt_exit_run", exp_o(1, 1, 1, 0, 0, 6'd0, 2'b00, 2'b00, 0));

        // Reset arriving during a flush cycle.
        reset_pulse();
        v = idle_vec(); v.br = 1; v.tgt = 6'h05; apply(v);
        step("rf_br", exp_o(0, 0, 0, 1, 1, 6'h05, 2'b00, 2'b00, 0));
        apply(idle_vec()); rst = 1'b1;
        step("rf_rst", 16'd0);
        rst = 1'b0;
        step("rf_after", 16'd0);

`ifdef NIOS_HAZARD_PERF_EN
        reset_pulse();
        @(negedge clk); check("flush_cnt_rst", flush_cnt, 16'd0);
        @(posedge clk); #1;
        v = idle_vec(); v.br = 1; v.tgt = 6'h05; apply(v);
        @(posedge clk); #1;
        apply(idle_vec());
        @(posedge clk); #1;
        @(negedge clk); check("flush_cnt_2", flush_cnt, 16'd2);
        @(posedge clk); #1;
        v = idle_vec(); v.valid = 1; v.rs = 5'd4; v.rd_e = 5'd4; v.rw_e = 1; v.ld_e = 1; apply(v);
        @(posedge clk); #1;
        apply(idle_vec());
        @(negedge clk); check("stall_cnt_1", stall_cnt, 16'd1);
        @(posedge clk); #1;
`endif

        // Random stimulus against the reference model.
        reset_pulse();
        m_halted = 0; m_after_stall = 0; m_flush_left = 0;
        for (int n = 0; n < 1500; n++) begin
            rst     = ($urandom_range(0, 29) == 0);
            valid   = ($urandom_range(0, 7) != 0);
            uses_rt = 1'($urandom);
            rs      = 5'($urandom_range(0, 3));
            rt      = 5'($urandom_range(0, 3));
            rd_e    = 5'($urandom_range(0, 3));
            rd_m    = 5'($urandom_range(0, 3));
            rd_wb   = 5'($urandom_range(0, 3));
            rw_e    = 1'($urandom);
            ld_e    = 1'($urandom);
            rw_m    = 1'($urandom);
            rw_wb   = 1'($urandom);
            br      = ($urandom_range(0, 5) == 0);
            tgt     = 6'($urandom);
            pc      = ($urandom_range(0, 23) == 0) ? HALT_PC : 6'($urandom_range(0, 13));
            @(negedge clk);
            model_cycle(e);
            check("random", outs_s, e);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nios_hazard_ctrl.md
Name: nios_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage NIOS II subset core (F/D/E/M/WB).
- Detects RAW hazards, generates operand-forwarding selects, inserts load-use stalls, and flushes the pipeline on a taken branch.
- Sequences end-of-program halt.
- Replaces the ad-hoc PC-compare and counter logic in the core with one FSM-driven block that sits beside the pipeline registers.

Parameters:
- PC_W, 6, width of PC / branch target.
- FLUSH_CYCLES, 2, cycles flush_D_18 stays asserted after a taken branch (legal 1..7).
- HALT_PC, 6'h0E, fetch PC at which the core halts.

Ports:
- clk_18  in  1  clock; all state on rising edge.
- rst_18  in  1  synchronous reset, active-high.
- valid_D_18  in  1  decode stage holds a real instruction.
- rs_D_18  in  5  decode source A.
- rt_D_18  in  5  decode source B.
- uses_rt_D_18  in  1  decode instruction reads rt.
- rd_E_18  in  5  execute-stage destination register.
- reg_rw_E_18  in  1  execute-stage instruction writes rd.
- is_load_E_18  in  1  execute-stage instruction is LDW.
- rd_M_18  in  5  memory-stage destination register.
- reg_rw_M_18  in  1  memory-stage instruction writes rd.
- rd_WB_18  in  5  write-back-stage destination register.
- reg_rw_WB_18  in  1  write-back-stage instruction writes rd.
- branch_taken_E_18  in  1  branch resolved taken in E.
- branch_tgt_E_18  in  PC_W  branch target PC.
- pc_F_18  in  PC_W  current fetch PC.
- stall_F_18  out  1  hold PC / IF register.
- stall_D_18  out  1  hold ID register.
- bubble_E_18  out  1  load NOP into the E register.
- flush_D_18  out  1  replace the ID register with a NOP.
- pc_load_18  out  1  load pc_tgt_18 into PC this edge.
- pc_tgt_18  out  PC_W  redirect target.
- fwd_a_sel_18  out  2  source-A operand select.
- fwd_b_sel_18  out  2  source-B operand select.
- halted_18  out  1  core halted.

Behaviour:
- Reset: state=RUN, flush counter=0. All outputs 0 while rst_18=1. Combinational outputs are also forced to 0 during reset.
- States: RUN, LSTALL, FLUSH, HALT. All stall/flush/forward outputs are combinational from the current state and inputs. State and counter are registered.
- Register r0 never creates a hazard; any match with rd=0 is ignored.
- Forward select encoding: 00 = register file, 01 = E ALU result, 10 = M result, 11 = WB result.
  - Priority E > M > WB.
  - A stage matches when its reg_rw=1, its rd≠0 and rd equals the source.
  - A source is never forwarded from E when is_load_E_18=1.
  - fwd_b_sel_18 = 00 when uses_rt_D_18=0.
  - Both selects = 00 when valid_D_18=0 or state≠RUN/LSTALL.
- Load-use hazard: valid_D_18 & is_load_E_18 & reg_rw_E_18 & rd_E_18≠0 & (rd_E_18==rs_D_18 | (uses_rt_D_18 & rd_E_18==rt_D_18)).
- RUN, priority order:
  1. branch_taken_E_18: pc_load_18=1, pc_tgt_18=branch_tgt_E_18, flush_D_18=1. Next state is FLUSH with counter=FLUSH_CYCLES-1, or RUN if FLUSH_CYCLES==1. The branch overrides load-use and halt detection in the same cycle.
  2. Load-use: stall_F_18=stall_D_18=bubble_E_18=1; next state LSTALL.
  3. pc_F_18==HALT_PC: next state HALT.
  4. Otherwise remain in RUN.
- LSTALL: exactly one stall cycle has already been taken. All stalls are released and the load result is forwarded from M (sel=10). branch_taken_E_18 is ignored because E holds a bubble. Next state RUN unconditionally.
- FLUSH: flush_D_18=1; hazard detection and forwarding are suppressed. Counter decrements each cycle; next state is RUN when the counter is 1 and the decrement occurs. A branch_taken_E_18 seen in FLUSH is ignored (E holds a flushed NOP).
- HALT: stall_F_18=1 and halted_18=1 permanently; stall_D_18=0 so the pipeline drains. Only rst_18 exits HALT.
- Reset mid-stall or mid-flush: state returns to RUN on the next edge and the counter clears. No stall or flush output persists past the reset cycle.
- pc_tgt_18 = 0 whenever pc_load_18 = 0.

Optional Feature:
- Macro: NIOS_HAZARD_PERF_EN.
- When defined, adds outputs stall_cnt_18[15:0] and flush_cnt_18[15:0]. Each is a saturating (sticks at 16'hFFFF) count of cycles with stall_D_18=1 and flush_D_18=1 respectively. Both are cleared by rst_18.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- ADDI r2 in M, ADD in D with rs=2, rt=3 and r3 in WB -> fwd_a_sel=10, fwd_b_sel=11, no stall.
- LDW r4 in E, ADD in D reading r4 -> cycle 0: stall_F=stall_D=bubble_E=1. Cycle 1 (LSTALL): stalls 0, fwd_a_sel=10. Cycle 2: RUN.
- BGT taken in E with target 6'h05, FLUSH_CYCLES=2 -> pc_load=1, pc_tgt=05, flush_D=1 for 2 consecutive cycles, then RUN. Load-use in D during the branch cycle is ignored.
- Hazard with rd=0 (write r0, read r0) -> fwd selects 00, no stall.
- pc_F=6'h0E in RUN -> next cycle halted=1, stall_F=1 held for 20 cycles. rst_18 pulse -> halted=0, state RUN.
- rst_18 asserted during a FLUSH cycle -> flush_D=0 on the following cycle. With NIOS_HAZARD_PERF_EN defined, flush_cnt=0 after reset and counts 2 per taken branch.
